// File: rtl/pipe_mac_unit.sv
// Pipelined three-operand multiply/add unit with valid/ready flow control on both sides.
// Optional overflow/borrow flag output enabled by defining PIPE_MAC_OVF_FLAG_EN.
module pipe_mac_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [1:0]       mode,
    input  logic             input_valid,
    output logic             input_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_ready,
    input  logic             result_ack,
`ifdef PIPE_MAC_OVF_FLAG_EN
    output logic             result_ovf,
`endif
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH;
`ifdef PIPE_MAC_OVF_FLAG_EN
    localparam int unsigned PART_W = WIDTH + 1;
`else
    localparam int unsigned PART_W = WIDTH;
`endif

    // First arithmetic step: product, A+B, or A*(B+C); top bit is the partial overflow
    function automatic logic [WIDTH:0] part_f(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c,
                                              input logic [1:0]       m);
        logic [WIDTH:0] sum;
        logic [PW-1:0]  prod;
        logic [WIDTH:0] res;
        sum  = (m == 2'b10) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, b} + {1'b0, c});
        prod = PW'(a) * PW'((m == 2'b11) ? sum[WIDTH-1:0] : b);
        if (m == 2'b10) begin
            res = sum;
        end else begin
            res = {(|prod[PW-1:WIDTH]) | ((m == 2'b11) & sum[WIDTH]), prod[WIDTH-1:0]};
        end
        return res;
    endfunction

    // Final step: add or subtract C; mode 11 is already resolved
    function automatic logic [WIDTH:0] final_f(input logic [WIDTH:0]   part,
                                               input logic [WIDTH-1:0] c,
                                               input logic [1:0]       m);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] diff;
        logic [WIDTH:0] res;
        sum  = {1'b0, part[WIDTH-1:0]} + {1'b0, c};
        diff = {1'b0, part[WIDTH-1:0]} - {1'b0, c};
        case (m)
            2'b01:   res = {~part[WIDTH] & diff[WIDTH], diff[WIDTH-1:0]};
            2'b11:   res = part;
            default: res = {part[WIDTH] | sum[WIDTH], sum[WIDTH-1:0]};
        endcase
        return res;
    endfunction

    logic [LAT-1:0]    vld;
    logic [LAT-1:0]    adv;
    logic              accept;
    logic [WIDTH-1:0]  s0_a;
    logic [WIDTH-1:0]  s0_b;
    logic [WIDTH-1:0]  s0_c;
    logic [1:0]        s0_mode;
    logic [PART_W-1:0] fin_c;

    // Advance chain ripples back from the consumer acknowledge
    always_comb begin
        logic go;
        adv = '0;
        go  = vld[LAT-1] & result_ack;
        adv[LAT-1] = go;
        for (int k = LAT - 2; k >= 0; k--) begin
            go     = vld[k] & (~vld[k+1] | go);
            adv[k] = go;
        end
    end

    assign input_ready  = ~vld[0] | adv[0];
    assign accept       = input_valid & input_ready;
    assign result_ready = vld[LAT-1];
    assign busy         = |vld;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= '0;
        end else begin
            vld[0] <= accept | (vld[0] & ~adv[0]);
            for (int k = 1; k < LAT; k++) begin
                vld[k] <= adv[k-1] | (vld[k] & ~adv[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s0_a    <= A;
            s0_b    <= B;
            s0_c    <= C;
            s0_mode <= mode;
        end
    end

    if (LAT == 2) begin : g_short
        assign fin_c = PART_W'(final_f(part_f(s0_a, s0_b, s0_c, s0_mode), s0_c, s0_mode));
    end else begin : g_deep
        localparam int unsigned NMID = LAT - 2;
        logic [PART_W-1:0] mid_p [NMID];
        logic [WIDTH-1:0]  mid_c [NMID];
        logic [1:0]        mid_m [NMID];

        // Stage 1 computes the partial result; later middle stages only carry it
        always_ff @(posedge clk) begin
            if (adv[0]) begin
                mid_p[0] <= PART_W'(part_f(s0_a, s0_b, s0_c, s0_mode));
                mid_c[0] <= s0_c;
                mid_m[0] <= s0_mode;
            end
            for (int j = 1; j < NMID; j++) begin
                if (adv[j]) begin
                    mid_p[j] <= mid_p[j-1];
                    mid_c[j] <= mid_c[j-1];
                    mid_m[j] <= mid_m[j-1];
                end
            end
        end

        assign fin_c = PART_W'(final_f((WIDTH+1)'(mid_p[NMID-1]), mid_c[NMID-1], mid_m[NMID-1]));
    end

    // Last stage holds its value while stalled or empty
    always_ff @(posedge clk) begin
        if (!reset) begin
            result <= '0;
        end else if (adv[LAT-2]) begin
            result <= fin_c[WIDTH-1:0];
        end
    end

`ifdef PIPE_MAC_OVF_FLAG_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_ovf <= 1'b0;
        end else if (adv[LAT-2]) begin
            result_ovf <= fin_c[WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mac_unit.sv
// Directed self-checking bench for pipe_mac_unit across four width/latency configurations.
module tb_pipe_mac_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] C = '0;
    logic [1:0]  mode = '0;
    logic        iv = 1'b0;
    logic        ack = 1'b0;
    logic [1:0]  sel = '0;

    logic [3:0]  ivd;
    logic [3:0]  ir_v;
    logic [3:0]  rr_v;
    logic [3:0]  busy_v;
    logic [31:0] res0, res2, res3;
    logic [7:0]  res1;
    logic        o_ir, o_rr, o_busy;
    logic [31:0] o_res;
`ifdef PIPE_MAC_OVF_FLAG_EN
    logic [3:0]  ovf_v;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ivd = iv ? (4'b0001 << sel) : 4'b0000;

    always_comb begin
        o_ir   = ir_v[sel];
        o_rr   = rr_v[sel];
        o_busy = busy_v[sel];
        case (sel)
            2'd0:    o_res = res0;
            2'd1:    o_res = {24'd0, res1};
            2'd2:    o_res = res2;
            default: o_res = res3;
        endcase
    end

    pipe_mac_unit #(.WIDTH(32), .LAT(3)) u_w32_l3 (
        .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .mode(mode),
        .input_valid(ivd[0]), .input_ready(ir_v[0]), .result(res0),
        .result_ready(rr_v[0]), .result_ack(ack),
`ifdef PIPE_MAC_OVF_FLAG_EN
        .result_ovf(ovf_v[0]),
`endif
        .busy(busy_v[0]));

    pipe_mac_unit #(.WIDTH(8), .LAT(3)) u_w8_l3 (
        .clk(clk), .reset(reset), .A(A[7:0]), .B(B[7:0]), .C(C[7:0]), .mode(mode),
        .input_valid(ivd[1]), .input_ready(ir_v[1]), .result(res1),
        .result_ready(rr_v[1]), .result_ack(ack),
`ifdef PIPE_MAC_OVF_FLAG_EN
        .result_ovf(ovf_v[1]),
`endif
        .busy(busy_v[1]));

    pipe_mac_unit #(.WIDTH(32), .LAT(2)) u_w32_l2 (
        .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .mode(mode),
        .input_valid(ivd[2]), .input_ready(ir_v[2]), .result(res2),
        .result_ready(rr_v[2]), .result_ack(ack),
`ifdef PIPE_MAC_OVF_FLAG_EN
        .result_ovf(ovf_v[2]),
`endif
        .busy(busy_v[2]));

    pipe_mac_unit #(.WIDTH(32), .LAT(8)) u_w32_l8 (
        .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .mode(mode),
        .input_valid(ivd[3]), .input_ready(ir_v[3]), .result(res3),
        .result_ready(rr_v[3]), .result_ack(ack),
`ifdef PIPE_MAC_OVF_FLAG_EN
        .result_ovf(ovf_v[3]),
`endif
        .busy(busy_v[3]));

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if (o_rr !== 1'b0) begin errors++; $display("FAIL reset_rr dut%0d: got %b expected 0", s, o_rr); end
            checks++;
            if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b expected 0", s, o_busy); end
            checks++;
            if (o_res !== 32'd0) begin errors++; $display("FAIL reset_result dut%0d: got %0d expected 0", s, o_res); end
            checks++;
            if (o_ir !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: got %b expected 1", s, o_ir); end
        end
    endtask

    // One triple with ack held high; checks latency, result and input_ready
    task automatic run_single(input logic [1:0] s, input int lat, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] c, input logic [1:0] m,
                              input logic [31:0] exp, input string name);
        int  cyc;
        bit  seen;
        bit  ir_ok;
        logic [31:0] got;
        @(posedge clk);
        #1 sel = s; ack = 1'b1; A = a; B = b; C = c; mode = m; iv = 1'b1;
        @(negedge clk);
        ir_ok = (o_ir === 1'b1);
        @(posedge clk);
        #1 iv = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        got  = '0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (o_ir !== 1'b1) ir_ok = 1'b0;
            if (o_rr === 1'b1) begin seen = 1'b1; got = o_res; end
        end
        checks++;
        if (!seen || cyc != lat) begin
            errors++; $display("FAIL %s_latency: got %0d cycles (seen=%b) expected %0d", name, cyc, seen, lat);
        end
        checks++;
        if (got !== exp) begin errors++; $display("FAIL %s_result: got %0d expected %0d", name, got, exp); end
        checks++;
        if (!ir_ok) begin errors++; $display("FAIL %s_input_ready: got 0 expected 1", name); end
    endtask

    task automatic test_single_modes();
        run_single(2'd0, 3, 32'd1, 32'd1, 32'd1, 2'b00, 32'd2, "mode00");
        run_single(2'd0, 3, 32'd3, 32'd2, 32'd1, 2'b01, 32'd5, "mode01");
        run_single(2'd0, 3, 32'd1, 32'd2, 32'd3, 2'b10, 32'd6, "mode10");
        run_single(2'd0, 3, 32'd3, 32'd2, 32'd1, 2'b11, 32'd9, "mode11");
        run_single(2'd0, 3, 32'hFFFF_FFFF, 32'd2, 32'd1, 2'b00, 32'hFFFF_FFFF, "mode00_wrap32");
    endtask

    task automatic test_stream(input logic [1:0] s, input int lat, input string name);
        logic [31:0] got[$];
        logic [31:0] exp [8];
        int first_cyc;
        int last_cyc;
        bit ir_ok;
        exp = '{32'd1, 32'd2, 32'd5, 32'd10, 32'd17, 32'd26, 32'd37, 32'd50};
        first_cyc = -1;
        last_cyc  = -1;
        ir_ok     = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1 sel = s; ack = 1'b1;
            if (cyc < 8) begin
                A = 32'(cyc); B = 32'(cyc); C = 32'd1; mode = 2'b00; iv = 1'b1;
            end else begin
                iv = 1'b0;
            end
            @(negedge clk);
            if (cyc < 8 && o_ir !== 1'b1) ir_ok = 1'b0;
            if (o_rr === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got.push_back(o_res);
            end
        end
        checks++;
        if (!ir_ok) begin errors++; $display("FAIL %s_input_ready: got 0 expected 1", name); end
        checks++;
        if (first_cyc != lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, first_cyc, lat); end
        checks++;
        if (got.size() != 8 || last_cyc - first_cyc != 7) begin
            errors++; $display("FAIL %s_count: got %0d results over span %0d expected 8 over 7", name, got.size(), last_cyc - first_cyc);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin errors++; $display("FAIL %s_value[%0d]: got %0d expected %0d", name, i, got[i], exp[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        logic [31:0] exp [5];
        logic [31:0] held;
        bit have_held;
        bit hold_bad;
        int idx;
        exp = '{32'd2, 32'd5, 32'd8, 32'd11, 32'd14};
        idx = 0; have_held = 1'b0; hold_bad = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
            @(posedge clk);
            #1 sel = 2'd0; ack = (cyc >= 8);
            if (idx < 5) begin
                A = 32'(idx + 1); B = 32'd2; C = 32'(idx); mode = 2'b00; iv = 1'b1;
            end else begin
                iv = 1'b0;
            end
            @(negedge clk);
            if (cyc == 7) begin
                checks++;
                if (idx != 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
                checks++;
                if (o_ir !== 1'b0) begin errors++; $display("FAIL bp_input_ready_full: got %b expected 0", o_ir); end
            end
            if (iv && o_ir === 1'b1) idx++;
            if (o_rr === 1'b1) begin
                if (!ack) begin
                    if (!have_held) begin held = o_res; have_held = 1'b1; end
                    else if (o_res !== held) hold_bad = 1'b1;
                end else begin
                    got.push_back(o_res);
                end
            end else if (have_held && !ack) begin
                hold_bad = 1'b1;
            end
        end
        iv = 1'b0;
        checks++;
        if (!have_held || hold_bad) begin errors++; $display("FAIL bp_hold: got held=%b unstable=%b expected held=1 unstable=0", have_held, hold_bad); end
        checks++;
        if (got.size() != 5) begin
            errors++; $display("FAIL bp_count: got %0d results expected 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_value[%0d]: got %0d expected %0d", i, got[i], exp[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        run_single(2'd1, 3, 32'd16, 32'd16, 32'd5, 2'b00, 32'd5, "wrap8_mac");
`ifdef PIPE_MAC_OVF_FLAG_EN
        checks++;
        if (ovf_v[1] !== 1'b1) begin errors++; $display("FAIL wrap8_mac_ovf: got %b expected 1", ovf_v[1]); end
`endif
        run_single(2'd1, 3, 32'd1, 32'd1, 32'd2, 2'b01, 32'd255, "wrap8_sub");
`ifdef PIPE_MAC_OVF_FLAG_EN
        checks++;
        if (ovf_v[1] !== 1'b1) begin errors++; $display("FAIL wrap8_sub_ovf: got %b expected 1", ovf_v[1]); end
`endif
        run_single(2'd1, 3, 32'd2, 32'd200, 32'd100, 2'b11, 32'd88, "wrap8_inner");
`ifdef PIPE_MAC_OVF_FLAG_EN
        checks++;
        if (ovf_v[1] !== 1'b1) begin errors++; $display("FAIL wrap8_inner_ovf: got %b expected 1", ovf_v[1]); end
        run_single(2'd1, 3, 32'd10, 32'd10, 32'd5, 2'b00, 32'd105, "fit8_mac");
        checks++;
        if (ovf_v[1] !== 1'b0) begin errors++; $display("FAIL fit8_mac_ovf: got %b expected 0", ovf_v[1]); end
`endif
    endtask

    task automatic test_reset_inflight();
        bit stale;
        @(posedge clk);
        #1 sel = 2'd0; ack = 1'b1; A = 32'd5; B = 32'd5; C = 32'd0; mode = 2'b00; iv = 1'b1;
        @(posedge clk);
        #1 A = 32'd6; B = 32'd6;
        @(posedge clk);
        #1 iv = 1'b0; reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_rr !== 1'b0) begin errors++; $display("FAIL rst_inflight_rr: got %b expected 0", o_rr); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_inflight_busy: got %b expected 0", o_busy); end
        checks++;
        if (o_res !== 32'd0) begin errors++; $display("FAIL rst_inflight_result: got %0d expected 0", o_res); end
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_rr === 1'b1) stale = 1'b1;
        end
        checks++;
        if (stale) begin errors++; $display("FAIL rst_inflight_stale: got result_ready=1 expected 0"); end
        run_single(2'd0, 3, 32'd2, 32'd3, 32'd4, 2'b10, 32'd9, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single_modes();
        test_stream(2'd0, 3, "stream_lat3");
        test_backpressure();
        test_wrap();
        test_reset_inflight();
        test_stream(2'd2, 2, "stream_lat2");
        test_stream(2'd3, 8, "stream_lat8");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_mac_unit.md
Name: pipe_mac_unit

Overview:
- Parametrised pipelined arithmetic unit. Next generation of the team's fixed three-operand pipeline.
- Accepts operand triples A, B, C with a per-transaction mode.
- Produces one result per accepted triple after LAT cycles.
- Supports full valid/ready backpressure on both sides. Sits between an operand producer and a result consumer in the exercise datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (4..64).
- LAT, 3, pipeline depth in register stages from input acceptance to result_ready (2..8).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- C  in  WIDTH  operand C, unsigned.
- mode  in  2  operation select, sampled with operands.
- input_valid  in  1  producer presents a valid triple.
- input_ready  out  1  unit can accept a triple this cycle.
- result  out  WIDTH  result of the oldest completed transaction.
- result_ready  out  1  result is valid (output-side valid).
- result_ack  in  1  consumer takes the result this cycle.
- busy  out  1  at least one stage holds a valid transaction.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All stage valid bits cleared; result=0; result_ready=0; busy=0.
  - In-flight transactions are discarded, not completed.
  - Reset has priority over every other event.
- Modes, all modulo 2^WIDTH:
  - 00: A*B + C
  - 01: A*B - C (two's-complement wrap)
  - 10: A + B + C
  - 11: A*(B + C), where the inner sum is truncated to WIDTH before the multiply.
- Acceptance: the triple is accepted on a rising edge where input_valid && input_ready. Operands and mode are captured into stage 0 on that edge.
- Pipeline structure:
  - Stage 0 holds the captured operands. Stage 1 computes the product or inner sum; middle stages carry values and valid bits; the final add/subtract resolves into the last stage.
  - Any legal LAT must give identical arithmetic results.
- Stage advance:
  - Stage k loads from stage k-1 when stage k is empty or stage k is itself advancing.
  - The last stage advances when result_ack && result_ready.
  - input_ready = !valid[0] || stage 0 advancing. It is combinational from result_ack and the valid bits; there is no combinational path from input_valid.
- Latency: with result_ack held at 1, a triple accepted at edge n gives result_ready=1 and a valid result after edge n+LAT-1, i.e. visible LAT cycles after presentation. Throughput is one triple per cycle.
- Backpressure:
  - While result_ready=1 and result_ack=0, result and result_ready hold stable.
  - Upstream stages fill bubbles, then stall. When all LAT stages are full, input_ready=0.
- Simultaneous accept and ack with a full pipeline: all stages shift, one enters and one leaves, and input_ready stays 1.
- result_ack while result_ready=0 is ignored.
- Empty pipeline: busy=0, result_ready=0, and result holds its last value (0 after reset).
- Ordering: results leave strictly in acceptance order. No reordering or dropping except on reset.

Optional Feature:
- Macro: PIPE_MAC_OVF_FLAG_EN.
- Defined: adds output result_ovf (1 bit), aligned with result and held under backpressure like result; reset value 0.
  - result_ovf=1 when the exact unsigned result does not fit WIDTH bits.
  - For mode 01 the flag means borrow (A*B < C).
  - For mode 11, overflow of the inner sum B+C also sets the flag.
- Undefined: the port is absent and no overflow logic is synthesised. The arithmetic result is identical in both builds.

Test Plan:
- Reset then WIDTH=32, LAT=3, result_ack=1, single triples:
  - A=1,B=1,C=1,mode=00 -> result=2.
  - A=3,B=2,C=1,mode=01 -> result=5.
  - A=1,B=2,C=3,mode=10 -> result=6.
  - A=3,B=2,C=1,mode=11 -> result=9.
  - Each result_ready rises exactly 3 cycles after acceptance, and input_ready stays 1.
- Back-to-back stream of 8 triples A=i,B=i,C=1,mode=00 (i=0..7) with ack=1 -> results 1,2,5,10,17,26,37,50 on consecutive cycles, in order.
- Hold result_ack=0 while streaming 5 triples:
  - input_ready drops after 3 acceptances (LAT=3), and result stays stable.
  - After ack=1, the remaining 2 are accepted; all 5 results appear in order with none lost or duplicated.
- Wrap-around, WIDTH=8: A=16,B=16,C=5,mode=00 -> result=5 (ovf=1 with PIPE_MAC_OVF_FLAG_EN). Same width, A=1,B=1,C=2,mode=01 -> result=255 (ovf=1).
- Reset asserted (reset=0) for one cycle with 2 transactions in flight -> result_ready=0, busy=0, result=0 on the next cycle; no stale result ever appears. A fresh triple afterwards completes normally.
- Repeat the stream test with LAT=2 and LAT=8 -> identical result sequence, and latency equals LAT.
